// File: rtl/grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: state encoding and
// the width helper used to size grant_id and the hold counter.
package arbiter_pkg;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = S_IDLE,
      GRANT   = S_GRANT,
      RELEASE = S_RELEASE
   } arbState_t;

   // Ceiling log2; clog2(1) == 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/grant_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_priority_pick
   import arbiter_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   ereq,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] index
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IDW:0]   first;
   logic [IDW:0]   sum;

   always_comb begin
      dbl   = {ereq, ereq} >> ptr;
      rot   = dbl[N-1:0];
      found = |rot;
      first = '0;
      // Scan downward so the lowest set bit of the rotated vector wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) first = (IDW+1)'(i);
      end
      sum = first + {1'b0, ptr};
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      index = sum[IDW-1:0];
   end

endmodule

// File: rtl/grant_arbiter.sv
// Round-robin arbiter for one shared resource with grounded requesters,
// bounded hold time and a dead turnaround cycle after each release.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no owner; pick next requester starting at ptr
//   GRANT   | owner holds grant until drop, mask or MAX_HOLD
//   RELEASE | dead turnaround cycle; ptr moves past last owner
module grant_arbiter
   import arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   ground_mask,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic           timeout
);

   localparam int HCW = (clog2(MAX_HOLD + 1) > 0) ? clog2(MAX_HOLD + 1) : 1;

   arbState_t      state, stateNext;
   logic [N-1:0]   eReq;
   logic [N-1:0]   grantNext;
   logic [IDW-1:0] idNext;
   logic [IDW-1:0] ptr, ptrNext;
   logic [HCW-1:0] holdCnt, holdNext;
   logic           timeoutNext;
   logic           pickFound;
   logic [IDW-1:0] pickIdx;

   assign eReq        = req & ~ground_mask;
   assign grant_valid = |grant;

   rr_priority_pick #(.N(N), .IDW(IDW)) uPick (
      .ereq  (eReq),
      .ptr   (ptr),
      .found (pickFound),
      .index (pickIdx)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         timeout  <= 1'b0;
         ptr      <= '0;
         holdCnt  <= '0;
      end else begin
         state    <= stateNext;
         grant    <= grantNext;
         grant_id <= idNext;
         timeout  <= timeoutNext;
         ptr      <= ptrNext;
         holdCnt  <= holdNext;
      end
   end

   always_comb begin
      stateNext   = state;
      grantNext   = grant;
      idNext      = grant_id;
      ptrNext     = ptr;
      holdNext    = holdCnt;
      timeoutNext = 1'b0;
      unique case (state)
         IDLE: begin
            if (pickFound) begin
               stateNext = GRANT;
               grantNext = N'(1) << pickIdx;
               idNext    = pickIdx;
               holdNext  = HCW'(1);
            end
         end
         GRANT: begin
            // A voluntary drop (or masking) takes priority over the timeout.
            if (!eReq[grant_id]) begin
               stateNext = RELEASE;
               grantNext = '0;
            end else if (MAX_HOLD != 0 && holdCnt == HCW'(MAX_HOLD)) begin
               stateNext   = RELEASE;
               grantNext   = '0;
               timeoutNext = 1'b1;
            end else if (holdCnt != '1) begin
               holdNext = holdCnt + HCW'(1);
            end
         end
         RELEASE: begin
            stateNext = IDLE;
            ptrNext   = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule
